// File: rtl/clock_supervisor.sv
// Purpose: reset sequencer and lock watchdog in front of clock_controller; pulses its reset, waits for lock, releases sys_rst.
// Latency: all outputs registered from next-state; a change of `locked` reaches the FSM two clk_33 edges after it is first sampled.
// Backpressure: none; free-running control block with no handshake, `locked` is the only status input.
//
// Ports:
//   clk_33        in   board clock, single domain
//   rst           in   synchronous active-high reset
//   locked        in   clock_controller lock status, asynchronous to clk_33
//   clkgen_rst_n  out  active-low reset to clock_controller
//   sys_rst       out  active-high reset for downstream logic
//   ready         out  high only while running with a stable lock
//   fail          out  high once the retry budget is exhausted (terminal)
//   retry_count   out  saturating count of retries taken, cleared only by rst
module clock_supervisor #(
    parameter int HOLD_CYCLES   = 16,
    parameter int LOCK_TIMEOUT  = 33000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 15
) (
    input  logic       clk_33,
    input  logic       rst,
    input  logic       locked,
    output logic       clkgen_rst_n,
    output logic       sys_rst,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retry_count
);

    typedef enum logic [2:0] {
        S_HOLD,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAIL
    } state_t;

    localparam logic [19:0] HOLD_LAST   = 20'(HOLD_CYCLES - 1);
    localparam logic [19:0] LOCK_LAST   = 20'(LOCK_TIMEOUT - 1);
    localparam logic [19:0] STABLE_LAST = 20'(STABLE_CYCLES - 1);
    localparam logic [3:0]  RETRY_MAX   = 4'(MAX_RETRIES);

    state_t      state;
    state_t      state_nxt;
    logic [19:0] timer;
    logic        sync_q;
    logic        locked_s;
    logic        retry_take;
    logic        retry_inc;

    always_comb begin
        state_nxt  = state;
        retry_take = 1'b0;
        retry_inc  = 1'b0;
        case (state)
            S_HOLD: begin
                if (timer == HOLD_LAST) begin
                    state_nxt = S_WAIT_LOCK;
                end
            end
            S_WAIT_LOCK: begin
                // Lock is checked first so a lock arriving on the timeout cycle wins.
                if (locked_s) begin
                    state_nxt = S_STABLE;
                end else if (timer == LOCK_LAST) begin
                    retry_take = 1'b1;
                end
            end
            S_STABLE: begin
                // Chatter during the stable window just restarts the wait, no retry.
                if (!locked_s) begin
                    state_nxt = S_WAIT_LOCK;
                end else if (timer == STABLE_LAST) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (!locked_s) begin
                    retry_take = 1'b1;
                end
            end
            S_FAIL: begin
                state_nxt = S_FAIL;
            end
            default: begin
                state_nxt = S_HOLD;
            end
        endcase

        if (retry_take) begin
            if (retry_count == RETRY_MAX) begin
                state_nxt = S_FAIL;
            end else begin
                state_nxt = S_HOLD;
                retry_inc = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_33) begin
        if (rst) begin
            sync_q       <= 1'b0;
            locked_s     <= 1'b0;
            state        <= S_HOLD;
            timer        <= 20'd0;
            retry_count  <= 4'd0;
            clkgen_rst_n <= 1'b0;
            sys_rst      <= 1'b1;
            ready        <= 1'b0;
            fail         <= 1'b0;
        end else begin
            sync_q   <= locked;
            locked_s <= sync_q;
            state    <= state_nxt;

            // Shared timer restarts on every state change; it saturates so that
            // long stays in RUN or FAIL never wrap it back through a compare value.
            if (state_nxt != state) begin
                timer <= 20'd0;
            end else if (timer != 20'hFFFFF) begin
                timer <= timer + 20'd1;
            end

            if (retry_inc) begin
                retry_count <= retry_count + 4'd1;
            end

            // Outputs decoded from next-state so they move on the same edge as the state.
            clkgen_rst_n <= (state_nxt != S_HOLD) && (state_nxt != S_FAIL);
            sys_rst      <= (state_nxt != S_RUN);
            ready        <= (state_nxt == S_RUN);
            fail         <= (state_nxt == S_FAIL);
        end
    end

endmodule

// File: tb/tb_clock_supervisor.sv
module tb_clock_supervisor;

    localparam int HOLD = 4;
    localparam int TMO  = 100;
    localparam int STB  = 16;
    localparam int MAXR = 2;

    // {clkgen_rst_n, sys_rst, ready, fail, retry_count}
    localparam logic [7:0] RST_V = 8'b0100_0000;

    logic       clk_33 = 1'b0;
    logic       rst    = 1'b1;
    logic       locked = 1'b0;
    logic       clkgen_rst_n;
    logic       sys_rst;
    logic       ready;
    logic       fail;
    logic [3:0] retry_count;
    logic [7:0] outs;

    clock_supervisor #(
        .HOLD_CYCLES  (HOLD),
        .LOCK_TIMEOUT (TMO),
        .STABLE_CYCLES(STB),
        .MAX_RETRIES  (MAXR)
    ) dut (
        .clk_33      (clk_33),
        .rst         (rst),
        .locked      (locked),
        .clkgen_rst_n(clkgen_rst_n),
        .sys_rst     (sys_rst),
        .ready       (ready),
        .fail        (fail),
        .retry_count (retry_count)
    );

    always #5 clk_33 = ~clk_33;

    assign outs = {clkgen_rst_n, sys_rst, ready, fail, retry_count};

    // Edge counter: value equals the number of the most recent rising edge.
    int cyc = 0;
    always @(posedge clk_33) cyc <= cyc + 1;

    typedef struct packed {
        int         cyc;
        logic [7:0] v;
    } exp_t;

    exp_t       exp_q[$];
    string      tag_q[$];
    int         n_chk  = 0;
    int         n_fail = 0;
    logic [7:0] prev;

    function automatic logic [7:0] ov(input logic cr, input logic sr, input logic rd,
                                      input logic fl, input logic [3:0] rc);
        return {cr, sr, rd, fl, rc};
    endfunction

    task automatic push(input int c, input logic [7:0] v, input string tag);
        exp_t e;
        e.cyc = c;
        e.v   = v;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic step();
        @(posedge clk_33);
        #2;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
        n_chk++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, got, want);
        end
    endtask

    task automatic drained(input string tag);
        step();
        n_chk++;
        assert (exp_q.size() === 0) else begin
            n_fail++;
            $error("FAIL %s: observed %0d pending events expected 0", tag, exp_q.size());
            exp_q.delete();
            tag_q.delete();
        end
    endtask

    // Scoreboard monitor: every output change must match the next expected event
    // in both edge number and value.
    task automatic mon();
        logic [7:0] cur;
        exp_t       e;
        string      t;
        cur = outs;
        if (cur !== prev) begin
            n_chk++;
            assert (exp_q.size() > 0) else begin
                n_fail++;
                $error("FAIL unexpected_change: observed %b at edge %0d expected no change from %b",
                       cur, cyc, prev);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                n_chk++;
                assert (cyc === e.cyc) else begin
                    n_fail++;
                    $error("FAIL %s_edge: observed edge %0d expected edge %0d", t, cyc, e.cyc);
                end
                n_chk++;
                assert (cur === e.v) else begin
                    n_fail++;
                    $error("FAIL %s_value: observed %b expected %b", t, cur, e.v);
                end
            end
            prev = cur;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int h, w, k, s, d, t, tf;

        // Reset state
        rst    = 1'b1;
        locked = 1'b0;
        repeat (3) step();
        chk("reset_outs", outs, RST_V);
        prev = outs;
        fork
            forever begin
                @(negedge clk_33);
                mon();
            end
        join_none

        // Clean bring-up: HOLD width, release 18 edges after lock is sampled
        rst = 1'b0;
        h   = cyc;
        w   = h + HOLD;
        push(w, ov(1, 1, 0, 0, 0), "hold_width");
        wait_to(w + 9);
        locked = 1'b1;
        k      = cyc + 1;
        push(k + 2 + STB, ov(1, 0, 1, 0, 0), "release");
        wait_to(k + 2 + STB);
        drained("bringup");

        // Lock loss in RUN: retry counted, HOLD again, normal re-release
        locked = 1'b0;
        k      = cyc + 1;
        push(k + 2, ov(0, 1, 0, 0, 1), "loss_in_run");
        push(k + 2 + HOLD, ov(1, 1, 0, 0, 1), "loss_hold");
        wait_to(k + 8);
        locked = 1'b1;
        k      = cyc + 1;
        push(k + 2 + STB, ov(1, 0, 1, 0, 1), "rerelease");
        wait_to(k + 2 + STB);
        drained("lock_loss");

        // Timeout/lock collision: locked_s rises on the cycle timer reaches TMO-1
        locked = 1'b0;
        k      = cyc + 1;
        push(k + 2, ov(0, 1, 0, 0, 2), "collide_hold");
        w = k + 2 + HOLD;
        push(w, ov(1, 1, 0, 0, 2), "collide_wait");
        wait_to(w + TMO - 3);
        locked = 1'b1;
        push(w + TMO + STB, ov(1, 0, 1, 0, 2), "collide_release");
        wait_to(w + TMO + 1);
        chk("collision_no_retry", outs, ov(1, 1, 0, 0, 2));
        wait_to(w + TMO + STB);
        drained("collision");

        // Reset in RUN, then timeout retries into FAIL
        rst    = 1'b1;
        locked = 1'b0;
        push(cyc + 1, RST_V, "rst_in_run");
        step();
        chk("rst_in_run_now", outs, RST_V);
        rst = 1'b0;
        h   = cyc;
        w   = h + HOLD;
        push(w, ov(1, 1, 0, 0, 0), "restart_wait");
        for (int r = 1; r <= MAXR; r++) begin
            t = w + (r - 1) * (HOLD + TMO) + TMO;
            push(t, ov(0, 1, 0, 0, 4'(r)), "timeout_retry");
            push(t + HOLD, ov(1, 1, 0, 0, 4'(r)), "timeout_rewait");
        end
        tf = w + MAXR * (HOLD + TMO) + TMO;
        push(tf, ov(0, 1, 0, 1, 4'(MAXR)), "enter_fail");
        wait_to(tf);
        locked = 1'b1;
        wait_to(tf + 40);
        chk("fail_terminal", outs, ov(0, 1, 0, 1, 4'(MAXR)));
        drained("timeout_chain");

        // Reset in FAIL, then bring-up with lock chatter in STABLE
        rst    = 1'b1;
        locked = 1'b0;
        push(cyc + 1, RST_V, "rst_in_fail");
        step();
        chk("rst_in_fail_now", outs, RST_V);
        rst = 1'b0;
        h   = cyc;
        w   = h + HOLD;
        push(w, ov(1, 1, 0, 0, 0), "chatter_wait");
        wait_to(w + 3);
        locked = 1'b1;
        k      = cyc + 1;
        s      = k + 2;
        d      = s + 8;
        wait_to(d - 1);
        locked = 1'b0;
        wait_to(d + 2);
        locked = 1'b1;
        push(d + 5 + STB, ov(1, 0, 1, 0, 0), "chatter_release");
        wait_to(k + 2 + STB + 1);
        chk("chatter_still_held", outs, ov(1, 1, 0, 0, 0));
        wait_to(d + 5 + STB);
        drained("chatter");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
